// File: rtl/double_dabble_pkg.sv
// Shared types and sizing for the sequential binary-to-BCD converter.
package double_dabble_pkg;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned DIGITS = 5;
    localparam int unsigned BCD_W  = 4 * DIGITS;
    localparam int unsigned CNT_W  = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit adjust: digits of 5 or more get +3 before the next doubling.
module bcd_add3 (
    input  logic [3:0] digit_in,
    output logic [3:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= 4'd5) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule

// File: rtl/double_dabble.sv
// Converts an unsigned binary value to BCD digits, one shift per clock, with a
// start/busy/done handshake. Result digits only change on the done edge or reset.
module double_dabble
    import double_dabble_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] binary_in,
    output logic [3:0]       bcd0,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd3,
    output logic [3:0]       bcd4,
    output logic             busy,
    output logic             done
);

    localparam int unsigned ScrW = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

    state_t          state;
    logic [WIDTH-1:0] bin_sr;
    logic [ScrW-1:0]  scratch;
    logic [ScrW-1:0]  adjusted;
    logic [ScrW-1:0]  shifted;
    logic [ScrW-1:0]  result;
    logic [CntW-1:0]  count;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_add3 u_add3 (
            .digit_in  (scratch[4*i +: 4]),
            .digit_out (adjusted[4*i +: 4])
        );
    end

    // Binary MSB feeds the scratch LSB as the combined register doubles.
    always_comb begin
        shifted = {adjusted[ScrW-2:0], bin_sr[WIDTH-1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bin_sr  <= '0;
            scratch <= '0;
            count   <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        bin_sr  <= binary_in;
                        scratch <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    scratch <= shifted;
                    bin_sr  <= bin_sr << 1;
                    count   <= count + 1'b1;
                    if (count == LastCount) begin
                        result <= shifted;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign bcd0 = result[3:0];
    assign bcd1 = result[7:4];
    assign bcd2 = result[11:8];
    assign bcd3 = result[15:12];
    assign bcd4 = result[19:16];

endmodule

// File: tb/tb_double_dabble.sv
// Self-checking bench for double_dabble; expected digits come from decimal arithmetic.
module tb_double_dabble;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] binary_in;
    logic [3:0]  bcd0, bcd1, bcd2, bcd3, bcd4;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    logic [19:0] last_exp;

    double_dabble dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .binary_in (binary_in),
        .bcd0      (bcd0),
        .bcd1      (bcd1),
        .bcd2      (bcd2),
        .bcd3      (bcd3),
        .bcd4      (bcd4),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] model(input int unsigned v);
        logic [19:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        r[19:16] = 4'((v / 10000) % 10);
        return r;
    endfunction

    function automatic logic [19:0] digits();
        return {bcd4, bcd3, bcd2, bcd1, bcd0};
    endfunction

    // Drives start for one edge; returns #1 after that edge with binary_in scrambled.
    task automatic start_conv(input logic [15:0] v);
        @(negedge clk);
        start     = 1'b1;
        binary_in = v;
        @(posedge clk);
        #1;
        start     = 1'b0;
        binary_in = 16'($urandom);
    endtask

    // n0 = edges already elapsed since the start edge.
    task automatic wait_done(input string name, input logic [19:0] exp, input int n0);
        int n = n0;
        bit busy_ok = 1'b1;
        bit hold_ok = 1'b1;
        while (!done && n < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (digits() !== last_exp) hold_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done=%b after %0d edges, required 1", name, done, n);
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, required 16", name, n);
        end
        checks++;
        if (!busy_ok || !hold_ok) begin
            errors++;
            $display("FAIL %s during conversion: busy_ok=%b hold_ok=%b, required 1 1",
                     name, busy_ok, hold_ok);
        end
        checks++;
        if (digits() !== exp || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s result: digits=%h busy=%b, required %h 0", name, digits(), busy,
                     exp);
        end
        last_exp = exp;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || digits() !== exp) begin
            errors++;
            $display("FAIL %s done pulse width: done=%b digits=%h, required 0 %h", name, done,
                     digits(), exp);
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        bit quiet = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || done !== 1'b0 || digits() !== last_exp) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL %s quiet: activity seen, required busy=0 done=0 digits=%h", name,
                     last_exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        binary_in = 16'd1234;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        last_exp = '0;
        checks++;
        if (digits() !== 20'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: digits=%h busy=%b done=%b, required 0 0 0", digits(), busy,
                     done);
        end
        expect_quiet("reset_idle", 5);
    endtask

    task automatic test_directed();
        start_conv(16'd1243);
        wait_done("conv_1243", model(1243), 0);
        start_conv(16'd65535);
        wait_done("conv_65535", model(65535), 0);
        start_conv(16'd0);
        wait_done("conv_0", model(0), 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [15:0] v;
            v = 16'($urandom);
            start_conv(v);
            wait_done("conv_random", model(int'(v)), 0);
        end
    endtask

    task automatic test_back_to_back();
        start_conv(16'd9999);
        wait_done("b2b_9999", model(9999), 0);
        // Re-enter the DONE cycle of a fresh 9999 and issue 10000 there.
        start_conv(16'd9999);
        begin
            int n = 0;
            while (!done && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        start_conv(16'd10000);
        wait_done("b2b_10000", model(10000), 0);
    endtask

    task automatic test_ignore_start();
        start_conv(16'd1243);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        binary_in = 16'd500;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("ignore_start", model(1243), 5);
        expect_quiet("ignore_no_restart", 20);
    endtask

    task automatic test_reset_abort();
        start_conv(16'd31337);
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_exp = '0;
        checks++;
        if (digits() !== 20'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort: digits=%h busy=%b done=%b, required 0 0 0", digits(), busy,
                     done);
        end
        expect_quiet("abort_no_done", 25);
        start_conv(16'd42);
        wait_done("after_abort_42", model(42), 0);
    endtask

    // A start seen in the DONE cycle begins the next conversion immediately,
    // so a held start yields one done pulse every 17 edges.
    task automatic test_held_start();
        int last_t = -1;
        int pulses = 0;
        bit overlap = 1'b0;
        bit spacing_ok = 1'b1;
        bit digits_ok = 1'b1;
        @(negedge clk);
        start = 1'b1;
        binary_in = 16'd7;
        for (int t = 0; t < 120; t++) begin
            @(posedge clk);
            #1;
            if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
            if (done === 1'b1) begin
                if (digits() !== model(7)) digits_ok = 1'b0;
                if (last_t >= 0 && t - last_t != 17) spacing_ok = 1'b0;
                last_t = t;
                pulses++;
            end
        end
        start = 1'b0;
        checks++;
        if (overlap || !spacing_ok || !digits_ok || pulses < 6) begin
            errors++;
            $display("FAIL held_start: overlap=%b spacing_ok=%b digits_ok=%b pulses=%0d, required 0 1 1 >=6",
                     overlap, spacing_ok, digits_ok, pulses);
        end
        begin
            int n = 0;
            while ((busy || done) && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL held_release: busy=%b done=%b, required 0 0", busy, done);
            end
        end
        last_exp = model(7);
        expect_quiet("held_idle", 5);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        binary_in = '0;
        last_exp = '0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_ignore_start();
        test_reset_abort();
        test_held_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
